branch_resolve: RTL

Resolves conditional branches against the direction predicted in decode and produces the fetch redirect on a mispredict. Annuls the delay slot of a not-taken branch-likely. Delivers the single-cycle retirement pulse (`branchM`, `actual_takeM`, `pcM`) that trains the global-history predictor. Sits between the decode-stage predictor and the memory stage, carrying branch metadata through E and M, and keeps saturating branch and mispredict counters for performance tuning.

---
 rtl/branch_resolve.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: resolves conditional branches in E against the decode-stage
// prediction, raises a held fetch redirect on a mispredict, annuls the delay
// slot of a not-taken branch-likely, carries branch metadata through E and M,
// emits a single retirement pulse per branch to train the predictor and keeps
// saturating branch / mispredict performance counters.
module branch_resolve #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branchD,
    input  logic            branchL_D,
    input  logic            pred_takeD,
    input  logic [PC_W-1:0] pcD,
    input  logic [31:0]     immD,
    input  logic            stallE,
    input  logic            flushE,
    input  logic            stallM,
    input  logic            flushM,
    input  logic            actual_takeE,
    input  logic            redirect_ready,
    input  logic            perf_clr,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            nullify_slotD,
    output logic            branchM,
    output logic            actual_takeM,
    output logic [PC_W-1:0] pcM,
    output logic [31:0]     perf_branch_cnt,
    output logic [31:0]     perf_mispred_cnt
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Decode-stage target: pc + 4 + (offset << 2), truncated to PC_W.
    // The shifted offset is kept signed so a wider PC sign-extends it.
    // ------------------------------------------------------------------
    logic signed [31:0] off_s;
    logic [PC_W-1:0]    tgt_d;

    assign off_s = {immD[29:0], 2'b00};
    assign tgt_d = pcD + PC_W'(4) + PC_W'(off_s);

    // ------------------------------------------------------------------
    // E stage register
    // ------------------------------------------------------------------
    logic            v_e_q;
    logic            lik_e_q;
    logic            pred_e_q;
    logic [PC_W-1:0] pc_e_q;
    logic [PC_W-1:0] tgt_e_q;

    // E register: flush kills the entry, otherwise load unless stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_e_q    <= 1'b0;
            lik_e_q  <= 1'b0;
            pred_e_q <= 1'b0;
            pc_e_q   <= '0;
            tgt_e_q  <= '0;
        end else if (flushE) begin
            v_e_q    <= 1'b0;
        end else if (!stallE) begin
            v_e_q    <= branchD;
            lik_e_q  <= branchL_D;
            pred_e_q <= pred_takeD;
            pc_e_q   <= pcD;
            tgt_e_q  <= tgt_d;
        end
    end

    // ------------------------------------------------------------------
    // E-stage resolution
    // ------------------------------------------------------------------
    logic            misp_e;
    logic [PC_W-1:0] fixpc_e;
    logic            redir_set;

    assign misp_e    = v_e_q & (pred_e_q ^ actual_takeE);
    // Not-taken correction resumes after the delay slot, hence +8.
    assign fixpc_e   = actual_takeE ? tgt_e_q : (pc_e_q + PC_W'(8));
    // A stalled E stage cannot annul D: the slot is not yet committed to.
    assign nullify_slotD = v_e_q & lik_e_q & ~actual_takeE & ~stallE;
    // Only a branch that actually leaves E this cycle may redirect fetch.
    assign redir_set = misp_e & ~stallE & ~flushE;

    // ------------------------------------------------------------------
    // Redirect request: held until fetch accepts it; a new set wins over
    // an accept and overwrites any pending target.
    // ------------------------------------------------------------------
    logic            redir_v_d;
    logic [PC_W-1:0] redir_pc_d;
    logic            redir_v_q;
    logic [PC_W-1:0] redir_pc_q;

    // Next-state for the redirect request.
    always_comb begin
        redir_v_d  = redir_v_q;
        redir_pc_d = redir_pc_q;
        if (redir_set) begin
            redir_v_d  = 1'b1;
            redir_pc_d = fixpc_e;
        end else if (redir_v_q && redirect_ready) begin
            redir_v_d  = 1'b0;
        end
    end

    // Redirect register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redir_v_q  <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign redirect_valid = redir_v_q;
    assign redirect_pc    = redir_pc_q;

    // ------------------------------------------------------------------
    // M stage register
    // ------------------------------------------------------------------
    logic            v_m_q;
    logic            take_m_q;
    logic            misp_m_q;
    logic [PC_W-1:0] pc_m_q;
    logic            v_m_d;

    // A branch held in E (or flushed out of it) must not appear in M.
    assign v_m_d = v_e_q & ~flushE & ~stallE;

    // M register: flush kills the entry, otherwise load from E unless stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_m_q    <= 1'b0;
            take_m_q <= 1'b0;
            misp_m_q <= 1'b0;
            pc_m_q   <= '0;
        end else if (flushM) begin
            v_m_q    <= 1'b0;
        end else if (!stallM) begin
            v_m_q    <= v_m_d;
            take_m_q <= actual_takeE;
            misp_m_q <= misp_e;
            pc_m_q   <= pc_e_q;
        end
    end

    // Pulse only in the cycle the branch leaves M, so a stall never
    // trains the predictor twice.
    assign branchM      = v_m_q & ~stallM;
    assign actual_takeM = take_m_q & v_m_q;
    assign pcM          = pc_m_q;

    // ------------------------------------------------------------------
    // Saturating performance counters; clear beats increment.
    // ------------------------------------------------------------------
    logic [31:0] br_cnt_q;
    logic [31:0] misp_cnt_q;

    // Retired-branch counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q <= '0;
        end else if (perf_clr) begin
            br_cnt_q <= '0;
        end else if (branchM && (br_cnt_q != CNT_MAX)) begin
            br_cnt_q <= br_cnt_q + 32'd1;
        end
    end

    // Retired-mispredict counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misp_cnt_q <= '0;
        end else if (perf_clr) begin
            misp_cnt_q <= '0;
        end else if (branchM && misp_m_q && (misp_cnt_q != CNT_MAX)) begin
            misp_cnt_q <= misp_cnt_q + 32'd1;
        end
    end

    assign perf_branch_cnt  = br_cnt_q;
    assign perf_mispred_cnt = misp_cnt_q;

endmodule
